sc_ienc_loader: RTL and testbench
=================================

# sc_ienc_loader

Sequential MIPS instruction encoder and program loader for the single-cycle CPU with I/O. It accepts symbolic instructions (mnemonic code plus register, shift and immediate fields) over a valid/ready handshake. Each instruction is encoded into a 32-bit word that the CPU's control unit decodes, and the words are written one per slot into instruction memory from a base address. It is the producer side of the instruction format the control unit consumes, and is used for boot loading and self-test program injection.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width.
- `BASE`, default 0: first word address written after `start`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a new program at `BASE`.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: block can accept an instruction.
- `in_mnem` in 5: mnemonic code.
- `in_rs`, `in_rt`, `in_rd`, `in_shamt` in 5 each: instruction fields.
- `in_imm` in 16: immediate or branch operand.
- `in_target` in 26: jump target field.
- `in_last` in 1: final instruction of the program.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out `ADDR_W`: write word address.
- `imem_wdata` out 32: encoded instruction.
- `busy` out 1: state is RUN or WRITE.
- `done` out 1: state is DONE.
- `err` out 1: state is ERR.
- `err_code` out 2: 1 = illegal mnemonic, 2 = overflow.
- `count` out `ADDR_W+1`: words written since `start`.

## Operation
- Mnemonic codes:
  - 0–7: add, sub, and, or, xor, sll, srl, sra.
  - 8: jr.
  - 9–12: addi, andi, ori, xori.
  - 13–14: lw, sw.
  - 15–16: beq, bne.
  - 17: lui.
  - 18–19: j, jal.
  - 20–31: illegal.
- R-type encoding: op = 0; funct is 20/22/24/25/26/00/02/03/08 hex for codes 0–8.
  - Shifts force rs to 0.
  - Arithmetic and logic ops force shamt to 0.
  - jr forces rt, rd and shamt to 0.
- I-type encoding: op is 08/0C/0D/0E/23/2B/04/05/0F hex for codes 9–17; word is {op, rs, rt, imm}. lui forces rs to 0.
- J-type encoding: op 02 (j) or 03 (jal); word is {op, in_target}.
- States: IDLE, RUN, WRITE, DONE, ERR.
  - `start` is honoured only in IDLE, DONE or ERR. It moves to RUN and clears `imem_addr` to `BASE`, `count` to 0, `err_code` to 0. `start` in RUN or WRITE is ignored.
  - RUN: `in_ready` = 1. On `in_valid & in_ready`:
    - Legal code: register the encoded word into `imem_wdata` and `in_last` into an internal flag, then go to WRITE.
    - Illegal code: go to ERR with `err_code` = 1 and no write.
  - WRITE: `imem_we` = 1 for exactly one cycle at the current `imem_addr`. Then `count` increments, `imem_addr` increments (wrapping modulo 2^ADDR_W), and the next state is:
    - DONE if the last flag is set;
    - ERR with `err_code` = 2 if the written address was 2^ADDR_W−1;
    - RUN otherwise.
- Overflow precedence: a `last` instruction written to the top address goes to DONE, not ERR.
- ERR and DONE hold until `start` or `reset`. `in_ready` = 0 in every state except RUN.

## Timing
- Reset values: state IDLE; all outputs 0, except `imem_addr` = `BASE`.
- `reset` mid-operation takes effect on the next edge: any pending write is dropped and `imem_we` is 0 in the following cycle.
- Latency: instruction accepted in cycle N gives `imem_we` high in cycle N+1 with stable address and data.
- Throughput: one instruction per 2 cycles.
- `count` and `imem_addr` update in cycle N+2.
- `in_valid` may stay high across WRITE; the block does not accept during WRITE.

## Configuration
- `IENC_PCREL_EN` defined: for beq and bne, `in_imm` is an absolute word target. The encoded offset is target − (imem_addr + 1), computed in 16-bit two's complement, truncated, with no range check.
- `IENC_PCREL_EN` undefined: `in_imm` is placed verbatim in the offset field.

## Structure
- Shared package `sc_isa_pkg` holds:
  - mnemonic code constants;
  - opcode and funct constants;
  - state encoding;
  - `err_code` values.
- Combinational sub-module `sc_ienc_word` maps the mnemonic and fields to the 32-bit word plus an illegal flag. The FSM, counters and write port stay in the top module.

## Test plan
- add $3,$1,$2 (code 0, rs=1, rt=2, rd=3) → `imem_we` at address 0 with data 0x00221820; `count` = 1.
- lw $4,8($5) followed by sll $2,$3,4 (rs input = 7), last on the second → data 0x8CA40008 then 0x00031100 (rs forced to 0); `done` = 1, `count` = 2.
- j with target 0x10 → 0x08000010. With `IENC_PCREL_EN`: beq $1,$2 at address 5 with imm = 2 → 0x1022FFFC. Without it: imm 0xFFFC passes through and gives the same word.
- Mnemonic 25 → `err` = 1, `err_code` = 1, no `imem_we`. A following `start` returns to RUN with `count` = 0.
- `ADDR_W` = 2, five instructions without last → four writes at addresses 0–3, then `err_code` = 2. The fifth instruction is never accepted.
- `reset` asserted in the WRITE-entry cycle → no `imem_we`; all outputs at reset values one cycle later.

Source files
------------

// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the single-cycle CPU instruction encoder/loader:
// mnemonic codes, opcode/funct values, loader FSM states and error codes.
package sc_isa_pkg;

  // Mnemonic codes presented on in_mnem (20..31 are illegal)
  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_XOR  = 5'd4;
  localparam logic [4:0] MN_SLL  = 5'd5;
  localparam logic [4:0] MN_SRL  = 5'd6;
  localparam logic [4:0] MN_SRA  = 5'd7;
  localparam logic [4:0] MN_JR   = 5'd8;
  localparam logic [4:0] MN_ADDI = 5'd9;
  localparam logic [4:0] MN_ANDI = 5'd10;
  localparam logic [4:0] MN_ORI  = 5'd11;
  localparam logic [4:0] MN_XORI = 5'd12;
  localparam logic [4:0] MN_LW   = 5'd13;
  localparam logic [4:0] MN_SW   = 5'd14;
  localparam logic [4:0] MN_BEQ  = 5'd15;
  localparam logic [4:0] MN_BNE  = 5'd16;
  localparam logic [4:0] MN_LUI  = 5'd17;
  localparam logic [4:0] MN_J    = 5'd18;
  localparam logic [4:0] MN_JAL  = 5'd19;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_JR  = 6'h08;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  // err_code values
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  // Branches are the only instructions whose immediate may be rebased
  function automatic logic is_branch(input logic [4:0] mn);
    return (mn == MN_BEQ) || (mn == MN_BNE);
  endfunction

endpackage

// File: rtl/sc_ienc_loader_if.sv
// Instruction-in / instruction-memory-out bundle for sc_ienc_loader.
// Handshake: an instruction transfers on a rising clock edge where
// in_valid and in_ready are both high; in_valid may be held high while
// in_ready is low, and the fields must stay stable until the transfer.
// dbg_state exposes the loader FSM state for checkers.
interface sc_ienc_loader_if #(parameter int ADDR_W = 6);
  import sc_isa_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;
  state_e            dbg_state;

  // Producer of instructions / consumer of memory writes
  modport master (
    output start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
           err_code, count, dbg_state
  );

  // The loader itself
  modport slave (
    input  start, in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
           err_code, count, dbg_state
  );
endinterface

// File: rtl/sc_ienc_word.sv
// Combinational MIPS encoder: mnemonic code + fields -> 32-bit word.
// Fields an instruction does not use are forced to zero; codes 20..31
// raise illegal and produce a zero word.
module sc_ienc_word
  import sc_isa_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select the format and pack the fields
  always_comb begin
    word_o    = 32'h0;
    illegal_o = 1'b0;
    case (mnem_i)
      MN_ADD:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_ADD};
      MN_SUB:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_SUB};
      MN_AND:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_AND};
      MN_OR:   word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_OR};
      MN_XOR:  word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'd0, F_XOR};
      MN_SLL:  word_o = {OP_RTYPE, 5'd0, rt_i, rd_i, shamt_i, F_SLL};
      MN_SRL:  word_o = {OP_RTYPE, 5'd0, rt_i, rd_i, shamt_i, F_SRL};
      MN_SRA:  word_o = {OP_RTYPE, 5'd0, rt_i, rd_i, shamt_i, F_SRA};
      MN_JR:   word_o = {OP_RTYPE, rs_i, 15'd0, F_JR};
      MN_ADDI: word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      MN_ANDI: word_o = {OP_ANDI, rs_i, rt_i, imm_i};
      MN_ORI:  word_o = {OP_ORI,  rs_i, rt_i, imm_i};
      MN_XORI: word_o = {OP_XORI, rs_i, rt_i, imm_i};
      MN_LW:   word_o = {OP_LW,   rs_i, rt_i, imm_i};
      MN_SW:   word_o = {OP_SW,   rs_i, rt_i, imm_i};
      MN_BEQ:  word_o = {OP_BEQ,  rs_i, rt_i, imm_i};
      MN_BNE:  word_o = {OP_BNE,  rs_i, rt_i, imm_i};
      MN_LUI:  word_o = {OP_LUI,  5'd0, rt_i, imm_i};
      MN_J:    word_o = {OP_J,    target_i};
      MN_JAL:  word_o = {OP_JAL,  target_i};
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/sc_ienc_loader.sv
// Sequential instruction encoder and program loader. Accepts one symbolic
// instruction per RUN cycle, encodes it, and writes it to instruction
// memory in the following WRITE cycle, advancing the address from BASE.
// Optional feature macro: IENC_PCREL_EN -- when defined, beq/bne in_imm is
// an absolute word target and is converted to a PC-relative offset.
module sc_ienc_loader
  import sc_isa_pkg::*;
#(
  parameter int                ADDR_W = 6,
  parameter logic [ADDR_W-1:0] BASE   = '0
) (
  input  logic              clock,
  input  logic              reset,
  sc_ienc_loader_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [1:0]        errc_q, errc_d;

  logic [15:0]       imm_eff;
  logic [31:0]       enc_word;
  logic              enc_illegal;

`ifdef IENC_PCREL_EN
  // Branch offset is relative to the slot after the one being written
  logic [15:0] pc_next;
  assign pc_next = 16'(addr_q) + 16'd1;
  assign imm_eff = is_branch(bus.in_mnem) ? (bus.in_imm - pc_next) : bus.in_imm;
`else
  assign imm_eff = bus.in_imm;
`endif

  sc_ienc_word u_word (
    .mnem_i    (bus.in_mnem),
    .rs_i      (bus.in_rs),
    .rt_i      (bus.in_rt),
    .rd_i      (bus.in_rd),
    .shamt_i   (bus.in_shamt),
    .imm_i     (imm_eff),
    .target_i  (bus.in_target),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // State and datapath registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      count_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      errc_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      errc_q  <= errc_d;
    end
  end

  // Next-state logic: accept in RUN, write in WRITE, park in DONE/ERR
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    errc_d  = errc_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d = ST_RUN;
          addr_d  = BASE;
          count_d = '0;
          errc_d  = ERR_NONE;
        end
      end
      ST_RUN: begin
        if (bus.in_valid) begin
          if (enc_illegal) begin
            state_d = ST_ERR;
            errc_d  = ERR_ILLEGAL;
          end else begin
            state_d = ST_WRITE;
            wdata_d = enc_word;
            last_d  = bus.in_last;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + (ADDR_W+1)'(1);
        addr_d  = addr_q + ADDR_W'(1);
        // A last instruction in the top slot still finishes cleanly
        if (last_q) begin
          state_d = ST_DONE;
        end else if (addr_q == {ADDR_W{1'b1}}) begin
          state_d = ST_ERR;
          errc_d  = ERR_OVERFLOW;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == ST_RUN);
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_WRITE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = (state_q == ST_ERR);
  assign bus.err_code   = errc_q;
  assign bus.count      = count_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_sc_ienc_loader.sv
// Bench for sc_ienc_loader: table of single-instruction programs plus
// hand-written multi-cycle sequences (multi-word program, branches,
// illegal code, address overflow on a 2-bit instance, reset mid-accept).
module tb_sc_ienc_loader;
  import sc_isa_pkg::*;

  logic clock;
  logic reset;

  sc_ienc_loader_if #(.ADDR_W(6)) bus ();
  sc_ienc_loader_if #(.ADDR_W(2)) bus_s ();

  sc_ienc_loader #(.ADDR_W(6), .BASE(6'd0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  sc_ienc_loader #(.ADDR_W(2), .BASE(2'd0)) dut_s (
    .clock (clock),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard: expected {addr, data} of every write on the 6-bit instance
  logic [37:0] exp_q[$];

  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {26'd0, bus.imem_addr, bus.imem_wdata}, 64'h0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        chk("write", {26'd0, bus.imem_addr, bus.imem_wdata}, {26'd0, e});
      end
    end
  end

  // Writes on the 2-bit instance must walk addresses 0,1,2,3
  int s_writes = 0;
  always @(negedge clock) begin
    if (bus_s.imem_we === 1'b1) begin
      chk($sformatf("s_addr%0d", s_writes), 64'(bus_s.imem_addr), 64'(s_writes % 4));
      s_writes++;
    end
  end

  // Driver tasks
  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Present one instruction, wait for acceptance, check the write strobe
  task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last, input logic push,
                      input logic [5:0] exp_addr, input logic [31:0] exp_word,
                      input string nm);
    int n;
    bus.in_mnem = mn; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tgt; bus.in_last = last;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_ready"}, 64'(bus.in_ready), 64'd1);
    if (bus.in_ready !== 1'b1) begin
      bus.in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({exp_addr, exp_word});
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    if (push) chk({nm, "_we"}, 64'(bus.imem_we), 64'd1);
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [4:0]  mn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[17];
  logic [15:0] beq_imm, bne_imm;

  initial begin
    int n;
    // Vectors: single-instruction programs, all with in_last = 1
    tbl[0]  = '{5'd0,  5'd1, 5'd2, 5'd3, 5'd5, 16'h0,    26'h0,       32'h00221820};
    tbl[1]  = '{5'd1,  5'd4, 5'd5, 5'd6, 5'd0, 16'h0,    26'h0,       32'h00853022};
    tbl[2]  = '{5'd2,  5'd1, 5'd2, 5'd3, 5'd7, 16'h0,    26'h0,       32'h00221824};
    tbl[3]  = '{5'd3,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0,       32'h00221825};
    tbl[4]  = '{5'd4,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0,       32'h00221826};
    tbl[5]  = '{5'd5,  5'd7, 5'd3, 5'd2, 5'd4, 16'h0,    26'h0,       32'h00031100};
    tbl[6]  = '{5'd6,  5'd9, 5'd3, 5'd2, 5'd4, 16'h0,    26'h0,       32'h00031102};
    tbl[7]  = '{5'd7,  5'd9, 5'd3, 5'd2, 5'd4, 16'h0,    26'h0,       32'h00031103};
    tbl[8]  = '{5'd8,  5'd31,5'd1, 5'd2, 5'd3, 16'h0,    26'h0,       32'h03E00008};
    tbl[9]  = '{5'd9,  5'd1, 5'd2, 5'd9, 5'd3, 16'h1234, 26'h0,       32'h20221234};
    tbl[10] = '{5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0,       32'h3022ABCD};
    tbl[11] = '{5'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0,       32'h3422ABCD};
    tbl[12] = '{5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'hABCD, 26'h0,       32'h3822ABCD};
    tbl[13] = '{5'd14, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0,       32'hACA40008};
    tbl[14] = '{5'd17, 5'd7, 5'd8, 5'd0, 5'd0, 16'hDEAD, 26'h0,       32'h3C08DEAD};
    tbl[15] = '{5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h10,      32'h08000010};
    tbl[16] = '{5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0,    26'h3FFFFFF, 32'h0FFFFFFF};
`ifdef IENC_PCREL_EN
    beq_imm = 16'd2;  // target 2 from slot 5 -> offset -4
    bne_imm = 16'd2;  // target 2 from slot 6 -> offset -5
`else
    beq_imm = 16'hFFFC;
    bne_imm = 16'hFFFB;
`endif

    bus.start = 0; bus.in_valid = 0; bus.in_mnem = 0; bus.in_rs = 0; bus.in_rt = 0;
    bus.in_rd = 0; bus.in_shamt = 0; bus.in_imm = 0; bus.in_target = 0; bus.in_last = 0;
    bus_s.start = 0; bus_s.in_valid = 0; bus_s.in_mnem = 0; bus_s.in_rs = 0; bus_s.in_rt = 0;
    bus_s.in_rd = 0; bus_s.in_shamt = 0; bus_s.in_imm = 0; bus_s.in_target = 0; bus_s.in_last = 0;

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we",    64'(bus.imem_we),  64'd0);
    chk("rst_addr",  64'(bus.imem_addr), 64'd0);
    chk("rst_data",  64'(bus.imem_wdata), 64'd0);
    chk("rst_flags", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_no_ready", 64'(bus.in_ready), 64'd0);

    // Table: each row is a one-word program
    for (int i = 0; i < 17; i++) begin
      do_start();
      send(tbl[i].mn, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].sh, tbl[i].imm, tbl[i].tgt,
           1'b1, 1'b1, 6'd0, tbl[i].exp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_done", i),  64'(bus.done),  64'd1);
      chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'd1);
      chk($sformatf("vec%0d_addr", i),  64'(bus.imem_addr), 64'd1);
    end

    // lw then sll (last) -> two writes, done, count 2
    do_start();
    chk("prog_ready", 64'(bus.in_ready), 64'd1);
    send(5'd13, 5'd5, 5'd4, 5'd0, 5'd0, 16'h0008, 26'h0, 1'b0, 1'b1, 6'd0, 32'h8CA40008, "lw");
    chk("lw_count", 64'(bus.count), 64'd1);
    chk("lw_busy",  64'(bus.busy),  64'd1);
    send(5'd5, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 1'b1, 6'd1, 32'h00031100, "sll");
    chk("prog_done",  64'(bus.done),  64'd1);
    chk("prog_count", 64'(bus.count), 64'd2);
    chk("prog_busy",  64'(bus.busy),  64'd0);

    // Five adds then beq at slot 5 and bne at slot 6; start in RUN ignored
    do_start();
    for (int i = 0; i < 5; i++) begin
      send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b1, 6'(i), 32'h00221820,
           $sformatf("fill%0d", i));
      if (i == 1) begin
        do_start();
        chk("start_in_run_addr",  64'(bus.imem_addr), 64'd2);
        chk("start_in_run_count", 64'(bus.count),     64'd2);
      end
    end
    send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, beq_imm, 26'h0, 1'b0, 1'b1, 6'd5, 32'h1022FFFC, "beq");
    send(5'd16, 5'd1, 5'd2, 5'd0, 5'd0, bne_imm, 26'h0, 1'b1, 1'b1, 6'd6, 32'h1422FFFB, "bne");
    chk("br_done",  64'(bus.done),  64'd1);
    chk("br_count", 64'(bus.count), 64'd7);

    // Illegal mnemonic 25 -> ERR code 1, no write; start recovers
    do_start();
    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 1'b0, 6'd0, 32'h0, "illegal");
    chk("ill_err",   64'(bus.err),      64'd1);
    chk("ill_code",  64'(bus.err_code), 64'd1);
    chk("ill_count", 64'(bus.count),    64'd0);
    chk("ill_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
    chk("ill_hold",  64'(bus.err),      64'd1);
    do_start();
    chk("rec_busy",  64'(bus.busy),     64'd1);
    chk("rec_ready", 64'(bus.in_ready), 64'd1);
    chk("rec_count", 64'(bus.count),    64'd0);
    chk("rec_code",  64'(bus.err_code), 64'd0);
    chk("rec_err",   64'(bus.err),      64'd0);

    // 2-bit instance: five non-last instructions, valid held high
    bus_s.start = 1'b1;
    @(posedge clock); #1;
    bus_s.start = 1'b0;
    bus_s.in_mnem = 5'd0; bus_s.in_rs = 5'd1; bus_s.in_rt = 5'd2; bus_s.in_rd = 5'd3;
    bus_s.in_last = 1'b0;
    bus_s.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      @(negedge clock);
      while (bus_s.in_ready !== 1'b1 && n < 6) begin
        @(negedge clock);
        n++;
      end
      if (i < 4) begin
        chk($sformatf("s_accept%0d", i), 64'(bus_s.in_ready), 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
      end else begin
        chk("s_fifth_refused", 64'(bus_s.in_ready), 64'd0);
      end
    end
    bus_s.in_valid = 1'b0;
    chk("s_err",    64'(bus_s.err),       64'd1);
    chk("s_code",   64'(bus_s.err_code),  64'd2);
    chk("s_count",  64'(bus_s.count),     64'd4);
    chk("s_addr",   64'(bus_s.imem_addr), 64'd0);
    chk("s_writes", 64'(s_writes),        64'd4);

    // Reset in the cycle an instruction is accepted drops the write
    do_start();
    bus.in_mnem = 5'd0; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clock);
    chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    chk("rst_mid_we",    64'(bus.imem_we),    64'd0);
    chk("rst_mid_addr",  64'(bus.imem_addr),  64'd0);
    chk("rst_mid_data",  64'(bus.imem_wdata), 64'd0);
    chk("rst_mid_flags", {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
    chk("rst_mid_count", 64'(bus.count),      64'd0);
    chk("rst_mid_state", 64'(bus.dbg_state),  64'(ST_IDLE));
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_mid_we2",   64'(bus.imem_we),    64'd0);
    repeat (2) @(posedge clock);
    #1;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
